// File: rtl/dcache_flush_walker_pkg.sv
// Shared types for the write-back dcache flush walker.
// The state enum lives here so the dcache wrapper and checkers can decode it.
package dcache_flush_walker_pkg;

    typedef enum logic [2:0] {
        FW_IDLE       = 3'd0,
        FW_READ_TAG   = 3'd1,
        FW_WAIT_TAG   = 3'd2,
        FW_WRITEBACK  = 3'd3,
        FW_INVALIDATE = 3'd4,
        FW_ACK        = 3'd5
    } flush_walk_state_e;

    // A line needs a writeback only when it is both valid and dirty.
    function automatic logic line_needs_wb(input logic valid, input logic dirty);
        return valid & dirty;
    endfunction

endpackage

// File: rtl/dcache_flush_walker_counter.sv
// Generic up-counter with synchronous clear; clear has priority over enable.
module dcache_flush_walker_counter #(
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             clear_i,
    input  logic             en_i,
    output logic [Width-1:0] q_o
);

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            q_o <= '0;
        end else if (en_i) begin
            q_o <= q_o + 1'b1;
        end
    end

endmodule

// File: rtl/dcache_flush_walker.sv
// Walks every set/way of the WB dcache tag array: writes back dirty lines,
// invalidates valid lines, then pulses flush_ack_o for one cycle.
module dcache_flush_walker
    import dcache_flush_walker_pkg::*;
#(
    parameter int unsigned NumSets = 256,
    parameter int unsigned NumWays = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    output logic                       flush_ack_o,
    output logic                       busy_o,
    output logic                       tag_req_o,
    input  logic                       tag_gnt_i,
    output logic [$clog2(NumSets)-1:0] tag_set_o,
    output logic [$clog2(NumWays)-1:0] tag_way_o,
    input  logic                       tag_rvalid_i,
    input  logic                       tag_valid_i,
    input  logic                       tag_dirty_i,
    output logic                       wb_valid_o,
    input  logic                       wb_ready_i,
    output logic                       inv_req_o,
    input  logic                       inv_gnt_i
);

    localparam int unsigned SetW = $clog2(NumSets);
    localparam int unsigned WayW = $clog2(NumWays);
    localparam int unsigned CntW = SetW + WayW;

    flush_walk_state_e state_q, state_d;
    logic [CntW-1:0]   line_q;
    logic              advance;
    logic              last_line;

    // Set in the upper bits so that a way wrap carries straight into the set.
    dcache_flush_walker_counter #(
        .Width (CntW)
    ) i_line_cnt (
        .clk_i   (clk_i),
        .clear_i ((state_q == FW_ACK) | rst_i),
        .en_i    (advance),
        .q_o     (line_q)
    );

    assign last_line = &line_q;
    assign tag_set_o = line_q[CntW-1:WayW];
    assign tag_way_o = line_q[WayW-1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FW_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        advance = 1'b0;
        case (state_q)
            FW_IDLE: begin
                if (flush_i) state_d = FW_READ_TAG;
            end
            FW_READ_TAG: begin
                if (tag_gnt_i) state_d = FW_WAIT_TAG;
            end
            FW_WAIT_TAG: begin
                // Missing rvalid is a protocol error; hold here rather than guess.
                if (tag_rvalid_i) begin
                    if (line_needs_wb(tag_valid_i, tag_dirty_i)) begin
                        state_d = FW_WRITEBACK;
                    end else if (tag_valid_i) begin
                        state_d = FW_INVALIDATE;
                    end else begin
                        advance = 1'b1;
                        state_d = last_line ? FW_ACK : FW_READ_TAG;
                    end
                end
            end
            FW_WRITEBACK: begin
                if (wb_ready_i) state_d = FW_INVALIDATE;
            end
            FW_INVALIDATE: begin
                if (inv_gnt_i) begin
                    advance = 1'b1;
                    state_d = last_line ? FW_ACK : FW_READ_TAG;
                end
            end
            FW_ACK: begin
                state_d = FW_IDLE;
            end
            default: begin
                state_d = FW_IDLE;
            end
        endcase
    end

    always_comb begin
        busy_o      = (state_q != FW_IDLE);
        tag_req_o   = (state_q == FW_READ_TAG);
        wb_valid_o  = (state_q == FW_WRITEBACK);
        inv_req_o   = (state_q == FW_INVALIDATE);
        flush_ack_o = (state_q == FW_ACK);
    end

`ifndef SYNTHESIS
    wait_tag_rvalid: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == FW_WAIT_TAG) |-> tag_rvalid_i);

    wb_valid_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (wb_valid_o && !wb_ready_i) |=>
            (wb_valid_o && $stable(tag_set_o) && $stable(tag_way_o)));
`endif

endmodule

// File: tb/tb_dcache_flush_walker.sv
// Directed bench for dcache_flush_walker with a 4-set x 2-way tag model.
module tb_dcache_flush_walker;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       flush_i;
    logic       flush_ack_o;
    logic       busy_o;
    logic       tag_req_o;
    logic       tag_gnt_i;
    logic [1:0] tag_set_o;
    logic       tag_way_o;
    logic       tag_rvalid_i;
    logic       tag_valid_i;
    logic       tag_dirty_i;
    logic       wb_valid_o;
    logic       wb_ready_i;
    logic       inv_req_o;
    logic       inv_gnt_i;

    logic mem_v [8];
    logic mem_d [8];

    int checks = 0;
    int errors = 0;

    int cyc, ack_cyc, ack_n, busy_n, busy_first, busy_last, n_tag;
    int first_tag_set, first_tag_way;
    int wb_cyc, wb_fire, wb_unstable, wb_set, wb_way;
    int inv_cyc, inv_fire, inv_set, inv_way;

    always #5 clk_i = ~clk_i;

    assign tag_valid_i = mem_v[{tag_set_o, tag_way_o}];
    assign tag_dirty_i = mem_d[{tag_set_o, tag_way_o}];

    dcache_flush_walker #(
        .NumSets (4),
        .NumWays (2)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .flush_ack_o  (flush_ack_o),
        .busy_o       (busy_o),
        .tag_req_o    (tag_req_o),
        .tag_gnt_i    (tag_gnt_i),
        .tag_set_o    (tag_set_o),
        .tag_way_o    (tag_way_o),
        .tag_rvalid_i (tag_rvalid_i),
        .tag_valid_i  (tag_valid_i),
        .tag_dirty_i  (tag_dirty_i),
        .wb_valid_o   (wb_valid_o),
        .wb_ready_i   (wb_ready_i),
        .inv_req_o    (inv_req_o),
        .inv_gnt_i    (inv_gnt_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 8; i++) begin
            mem_v[i] = 1'b0;
            mem_d[i] = 1'b0;
        end
    endtask

    // Raises flush_i, then plays the tag/wb/inv responder one cycle at a time.
    // cyc counts from the edge that samples flush_i (cycle 0).
    task automatic run_walk(input int wb_delay, input int inv_delay, input int drop_at,
                            input bit hold_flush, input bit stop_on_wb);
        int wb_run = 0;
        int inv_run = 0;
        bit prev_fire = 1'b0;
        bit done = 1'b0;
        cyc = 0; ack_cyc = -1; ack_n = 0; busy_n = 0; busy_first = -1; busy_last = -1;
        n_tag = 0; first_tag_set = -1; first_tag_way = -1;
        wb_cyc = 0; wb_fire = 0; wb_unstable = 0; wb_set = -1; wb_way = -1;
        inv_cyc = 0; inv_fire = 0; inv_set = -1; inv_way = -1;
        tag_gnt_i = 0; tag_rvalid_i = 0; wb_ready_i = 0; inv_gnt_i = 0;
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        while (!done && cyc < 200) begin
            cyc++;
            if (flush_ack_o) begin
                ack_n++;
                if (ack_cyc < 0) ack_cyc = cyc;
                done = 1'b1;
                if (!hold_flush) flush_i = 1'b0;
            end
            if (busy_o) begin
                busy_n++;
                if (busy_first < 0) busy_first = cyc;
                busy_last = cyc;
            end
            if (tag_req_o) begin
                n_tag++;
                if (first_tag_set < 0) begin
                    first_tag_set = tag_set_o;
                    first_tag_way = tag_way_o;
                end
            end
            tag_rvalid_i = prev_fire;
            prev_fire = tag_req_o;
            tag_gnt_i = tag_req_o;
            if (wb_valid_o) begin
                if (wb_run == 0) begin
                    wb_set = tag_set_o;
                    wb_way = tag_way_o;
                end else if (wb_set != tag_set_o || wb_way != tag_way_o) begin
                    wb_unstable++;
                end
                wb_run++;
                wb_cyc++;
                wb_ready_i = (wb_run > wb_delay);
                if (wb_ready_i) wb_fire++;
            end else begin
                wb_run = 0;
                wb_ready_i = 1'b0;
            end
            if (inv_req_o) begin
                if (inv_run == 0) begin
                    inv_set = tag_set_o;
                    inv_way = tag_way_o;
                end
                inv_run++;
                inv_cyc++;
                inv_gnt_i = (inv_run > inv_delay);
                if (inv_gnt_i) inv_fire++;
            end else begin
                inv_run = 0;
                inv_gnt_i = 1'b0;
            end
            if (cyc == drop_at) flush_i = 1'b0;
            if (done || (stop_on_wb && wb_valid_o)) break;
            @(posedge clk_i); #1;
        end
    endtask

    initial begin
        // Reset
        clear_mem();
        rst_i = 1'b1; flush_i = 0; tag_gnt_i = 0; tag_rvalid_i = 0;
        wb_ready_i = 0; inv_gnt_i = 0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_busy", busy_o, 0);
        check("rst_ack", flush_ack_o, 0);
        check("rst_tag_req", tag_req_o, 0);
        check("rst_wb_valid", wb_valid_o, 0);
        check("rst_inv_req", inv_req_o, 0);
        check("rst_set", tag_set_o, 0);
        check("rst_way", tag_way_o, 0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // All lines invalid
        run_walk(0, 0, -1, 1'b0, 1'b0);
        check("inv_all_ack_cyc", ack_cyc, 17);
        check("inv_all_ack_n", ack_n, 1);
        check("inv_all_tag_reads", n_tag, 8);
        check("inv_all_first_set", first_tag_set, 0);
        check("inv_all_first_way", first_tag_way, 0);
        check("inv_all_wb_cyc", wb_cyc, 0);
        check("inv_all_inv_cyc", inv_cyc, 0);
        check("inv_all_busy_first", busy_first, 1);
        check("inv_all_busy_last", busy_last, 17);
        check("inv_all_busy_n", busy_n, 17);
        @(posedge clk_i); #1;
        check("post_ack_busy", busy_o, 0);
        check("post_ack_ack", flush_ack_o, 0);
        @(posedge clk_i); #1;
        check("no_restart_tag_req", tag_req_o, 0);
        check("no_restart_busy", busy_o, 0);

        // Line (2,1) dirty
        clear_mem();
        mem_v[5] = 1'b1; mem_d[5] = 1'b1;
        run_walk(0, 0, -1, 1'b0, 1'b0);
        check("dirty_ack_cyc", ack_cyc, 19);
        check("dirty_wb_fire", wb_fire, 1);
        check("dirty_wb_cyc", wb_cyc, 1);
        check("dirty_inv_fire", inv_fire, 1);
        check("dirty_wb_set", wb_set, 2);
        check("dirty_wb_way", wb_way, 1);
        check("dirty_inv_set", inv_set, 2);
        check("dirty_inv_way", inv_way, 1);
        @(posedge clk_i); #1;

        // Line (0,0) clean, inv grant delayed 3 cycles
        clear_mem();
        mem_v[0] = 1'b1;
        run_walk(0, 3, -1, 1'b0, 1'b0);
        check("clean_ack_cyc", ack_cyc, 21);
        check("clean_inv_cyc", inv_cyc, 4);
        check("clean_inv_fire", inv_fire, 1);
        check("clean_wb_cyc", wb_cyc, 0);
        check("clean_inv_set", inv_set, 0);
        check("clean_inv_way", inv_way, 0);
        @(posedge clk_i); #1;

        // Line (0,1) dirty, wb_ready low for 5 cycles
        clear_mem();
        mem_v[1] = 1'b1; mem_d[1] = 1'b1;
        run_walk(5, 0, -1, 1'b0, 1'b0);
        check("wbstall_wb_cyc", wb_cyc, 6);
        check("wbstall_unstable", wb_unstable, 0);
        check("wbstall_wb_set", wb_set, 0);
        check("wbstall_wb_way", wb_way, 1);
        check("wbstall_inv_cyc", inv_cyc, 1);
        check("wbstall_ack_cyc", ack_cyc, 24);
        @(posedge clk_i); #1;

        // Reset during WRITEBACK of line (1,0)
        clear_mem();
        mem_v[2] = 1'b1; mem_d[2] = 1'b1;
        run_walk(100, 0, -1, 1'b0, 1'b1);
        check("rstwb_wb_cyc_at", cyc, 7);
        check("rstwb_wb_set", wb_set, 1);
        check("rstwb_wb_way", wb_way, 0);
        rst_i = 1'b1; flush_i = 1'b0; wb_ready_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        check("rstwb_busy", busy_o, 0);
        check("rstwb_ack", flush_ack_o, 0);
        check("rstwb_wb_valid", wb_valid_o, 0);
        check("rstwb_set", tag_set_o, 0);
        check("rstwb_way", tag_way_o, 0);
        clear_mem();
        run_walk(0, 0, -1, 1'b0, 1'b0);
        check("restart_first_set", first_tag_set, 0);
        check("restart_first_way", first_tag_way, 0);
        check("restart_ack_cyc", ack_cyc, 17);
        @(posedge clk_i); #1;

        // flush_i dropped mid-walk
        run_walk(0, 0, 5, 1'b0, 1'b0);
        check("drop_ack_cyc", ack_cyc, 17);
        check("drop_tag_reads", n_tag, 8);
        @(posedge clk_i); #1;

        // flush_i held across ack starts a second walk
        run_walk(0, 0, -1, 1'b1, 1'b0);
        check("hold_ack_cyc", ack_cyc, 17);
        @(posedge clk_i); #1;
        check("hold_idle_busy", busy_o, 0);
        @(posedge clk_i); #1;
        check("hold_restart_tag_req", tag_req_o, 1);
        check("hold_restart_set", tag_set_o, 0);
        check("hold_restart_way", tag_way_o, 0);
        rst_i = 1'b1; flush_i = 1'b0; tag_gnt_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_flush_walker.md
# dcache_flush_walker

Write-back data-cache flush sequencer. It sits directly downstream of the core flush controller: it consumes that controller's registered `flush_dcache_o` level and returns `flush_dcache_ack_i` and `cache_busy_i` to it. It walks every set and way of the WB dcache tag array. Dirty lines are written back and valid lines are invalidated, after which the requester is acknowledged.

## Interface
Parameters:
- `NumSets`, default 256: sets in the dcache. Power of two, ≥2.
- `NumWays`, default 8: ways per set. Power of two, ≥2.

Ports:
- `clk_i`  in  1  core clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `flush_i`  in  1  flush request level from the flush controller; held until ack.
- `flush_ack_o`  out  1  single-cycle pulse: flush complete.
- `busy_o`  out  1  high whenever the walker is not IDLE (feeds the drain counter).
- `tag_req_o`  out  1  tag-array read request.
- `tag_gnt_i`  in  1  tag read grant.
- `tag_set_o`  out  $clog2(NumSets)  set index for all tag, wb and inv requests.
- `tag_way_o`  out  $clog2(NumWays)  way index for all tag, wb and inv requests.
- `tag_rvalid_i`  in  1  tag data valid, exactly 1 cycle after grant.
- `tag_valid_i`, `tag_dirty_i`  in  1 each  line state, sampled when `tag_rvalid_i`=1.
- `wb_valid_o`  out  1  writeback request for the line at the current set/way.
- `wb_ready_i`  in  1  writeback accepted; the line is fully handled by the cache miss unit.
- `inv_req_o`  out  1  clear valid/dirty bits of the current line.
- `inv_gnt_i`  in  1  invalidate grant; the write takes effect on this edge.

## Operation
States: IDLE, READ_TAG, WAIT_TAG, WRITEBACK, INVALIDATE, ACK.
- IDLE: set/way counters are 0. `flush_i`=1 → READ_TAG.
- READ_TAG: `tag_req_o`=1 until `tag_gnt_i`; on grant → WAIT_TAG.
- WAIT_TAG: the response is required this cycle (`tag_rvalid_i`=1); it is sampled and the next state is chosen:
  - dirty (valid=1, dirty=1) → WRITEBACK.
  - valid and clean → INVALIDATE.
  - invalid → advance the line.
  - `tag_rvalid_i`=0 here is a protocol error; it is covered by an assertion and the walker stays in WAIT_TAG.
- WRITEBACK: `wb_valid_o`=1 and held stable until `wb_ready_i`; then → INVALIDATE.
- INVALIDATE: `inv_req_o`=1 until `inv_gnt_i`; then advance the line.
- Advance: way+1. On way wrap, way=0 and set+1.
  - If the line just handled was (NumSets-1, NumWays-1) → ACK.
  - Otherwise → READ_TAG.
- ACK: `flush_ack_o`=1 for one cycle, counters are cleared, → IDLE.
- `flush_i` is ignored outside IDLE. Deasserting it mid-walk does not abort the walk.
- `tag_set_o`/`tag_way_o` are driven from the counters in every state and stay constant while a line is in flight.

## Timing
- Reset values: state IDLE, counters 0, and every output 0.
- `flush_ack_o`, `busy_o` and all request outputs are decoded from registered state only; they have no combinational path from any input.
- Per-line cost with immediate grants/ready: invalid 2 cycles, valid clean 3 cycles, dirty 4 cycles. Each stalled handshake cycle adds 1.
- Start latency: `flush_i` sampled high in IDLE at cycle t → `tag_req_o` at t+1.
- Full walk of an all-invalid cache with immediate grants: ack at t+1+2·NumSets·NumWays.
- The requester drops `flush_i` in the cycle after ack; the walker sees IDLE with `flush_i`=0, so there is no spurious restart.
- A `flush_i` that is still high in IDLE after ack starts a fresh walk. This is legal.
- `rst_i` mid-walk: next cycle is IDLE, no ack, and in-flight requests are dropped. The cache is reset alongside.

## Structure
- State enum `flush_walk_state_e` goes in `ariane_pkg` so that the dcache wrapper and assertions share it.
- Set/way indexing uses the existing generic `counter` module:
  - one instance of width $clog2(NumSets)+$clog2(NumWays), with the upper bits as set and the lower bits as way;
  - `clear_i` tied to ACK|`rst_i`;
  - `en_i` high on advance.
- Protocol assertions (WAIT_TAG rvalid, `wb_valid_o` stability) live in the same file under a `pragma translate_off` guard.

## Test plan
Bench parameters: NumSets=4, NumWays=2, grants immediate unless stated.
- All lines invalid, `flush_i` rising at cycle 0 → 8 tag reads, no `wb_valid_o`/`inv_req_o`, `flush_ack_o` exactly at cycle 17, `busy_o` high cycles 1–17.
- Line (2,1) dirty, all others invalid → one `wb_valid_o` and one `inv_req_o`, both with set=2, way=1; ack at cycle 19.
- Line (0,0) valid clean, `inv_gnt_i` delayed 3 cycles → `inv_req_o` held 4 cycles, no writeback, ack at cycle 21.
- Dirty line with `wb_ready_i` low 5 cycles → `wb_valid_o`, set and way stable across all 6 cycles; walk resumes after ready.
- `rst_i` asserted during WRITEBACK of line (1,0) → next cycle IDLE, `busy_o`=0, no ack. A new `flush_i` then restarts from (0,0).
- `flush_i` held high across the ack → second walk starts the cycle after IDLE. `flush_i` toggled low mid-walk → walk completes unaffected.
